// File: rtl/ram_dp_fifo_pkg.sv
// Shared sizing constants for the dual-port-RAM backed FIFO controller.
package ram_dp_fifo_pkg;

   localparam int unsigned DW_DEF   = 8;
   localparam int unsigned AW_DEF   = 6;
   localparam int unsigned DEPTH    = 2 ** AW_DEF;
   localparam int unsigned CAP      = DEPTH + 2;
   localparam int unsigned PTR_W    = AW_DEF;
   localparam int unsigned CNT_W    = AW_DEF + 1;
   localparam int unsigned OB_CNT_W = 2;

endpackage

// File: rtl/fifo_out_buf.sv
// Two-entry skid buffer holding words fetched from RAM port B; head is the
// registered first-word-fall-through output.
module fifo_out_buf
   import ram_dp_fifo_pkg::*;
#(
   parameter int unsigned DW = DW_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cap_valid,
   input  logic [DW-1:0]       cap_data,
   input  logic                pop,
   output logic                valid,
   output logic [DW-1:0]       data,
   output logic [OB_CNT_W-1:0] ob_cnt
);

   logic [DW-1:0]       head;
   logic [DW-1:0]       tail;
   logic [OB_CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else begin
         case ({cap_valid, pop})
            2'b10: begin
               if (cnt == '0) head <= cap_data;
               else           tail <= cap_data;
               cnt <= cnt + OB_CNT_W'(1);
            end
            2'b01: begin
               head <= tail;
               cnt  <= cnt - OB_CNT_W'(1);
            end
            2'b11: begin
               // Single entry: the new word becomes head directly; two entries shift.
               if (cnt == OB_CNT_W'(1)) begin
                  head <= cap_data;
               end else begin
                  head <= tail;
                  tail <= cap_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign valid  = (cnt != '0);
   assign data   = head;
   assign ob_cnt = cnt;

   a_no_overflow : assert property (@(posedge clk) disable iff (rst)
      !(cap_valid && !pop && cnt == OB_CNT_W'(2)));

endmodule

// File: rtl/ram_dp_fifo_ctrl.sv
// FIFO controller driving a 64x8 dual-port RAM: port A writes, port B
// prefetches into a 2-entry output buffer for a FWFT consumer stream.
module ram_dp_fifo_ctrl
   import ram_dp_fifo_pkg::*;
#(
   parameter int unsigned DW = DW_DEF,
   parameter int unsigned AW = AW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_valid_in,
   output logic          wr_ready_out,
   input  logic [DW-1:0] wr_data_in,
   output logic          rd_valid_out,
   input  logic          rd_ready_in,
   output logic [DW-1:0] rd_data_out,
   output logic [AW:0]   count_out,
   output logic          ram_we_a_out,
   output logic [AW-1:0] ram_addr_a_out,
   output logic [DW-1:0] ram_data_a_out,
   output logic          ram_we_b_out,
   output logic [AW-1:0] ram_addr_b_out,
   input  logic [DW-1:0] ram_data_b_in
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(2 ** AW);
   localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

   logic [AW-1:0]       wptr;
   logic [AW-1:0]       rptr;
   logic [AW:0]         ram_cnt;
   logic                inflight;
   logic [OB_CNT_W-1:0] ob_cnt;
   logic                push;
   logic                pop;
   logic                issue;
   logic [2:0]          occ_after;

   assign wr_ready_out = (ram_cnt != FULL_CNT);
   assign push         = wr_valid_in & wr_ready_out;
   assign pop          = rd_valid_out & rd_ready_in;

   // Buffer occupancy once this cycle's pop and pending capture settle; a new
   // read is only issued if its data is guaranteed a free slot.
   assign occ_after = 3'(ob_cnt) + 3'(inflight) - 3'(pop);
   assign issue     = (ram_cnt != '0) && (occ_after < 3'd2);

   assign ram_we_a_out   = push;
   assign ram_addr_a_out = wptr;
   assign ram_data_a_out = wr_data_in;
   assign ram_we_b_out   = 1'b0;
   assign ram_addr_b_out = rptr;

   assign count_out = ram_cnt + (AW+1)'(ob_cnt) + (AW+1)'(inflight);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr     <= '0;
         rptr     <= '0;
         ram_cnt  <= '0;
         inflight <= 1'b0;
      end else begin
         if (push)  wptr <= wptr + AW'(1);
         if (issue) rptr <= rptr + AW'(1);
         inflight <= issue;
         case ({push, issue})
            2'b10:   ram_cnt <= ram_cnt + CNT_ONE;
            2'b01:   ram_cnt <= ram_cnt - CNT_ONE;
            default: ;
         endcase
      end
   end

   fifo_out_buf #(.DW(DW)) u_out_buf (
      .clk       (clk),
      .rst       (rst),
      .cap_valid (inflight),
      .cap_data  (ram_data_b_in),
      .pop       (pop),
      .valid     (rd_valid_out),
      .data      (rd_data_out),
      .ob_cnt    (ob_cnt)
   );

endmodule

// File: tb/tb_ram_dp_fifo_ctrl.sv
// Self-checking bench: RAM model plus a queue-based reference of FIFO contents.
module tb_ram_dp_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_valid_in = 1'b0;
   logic       wr_ready_out;
   logic [7:0] wr_data_in = '0;
   logic       rd_valid_out;
   logic       rd_ready_in = 1'b0;
   logic [7:0] rd_data_out;
   logic [6:0] count_out;
   logic       ram_we_a_out;
   logic [5:0] ram_addr_a_out;
   logic [7:0] ram_data_a_out;
   logic       ram_we_b_out;
   logic [5:0] ram_addr_b_out;
   logic [7:0] ram_data_b_in;

   ram_dp_fifo_ctrl #(.DW(8), .AW(6)) dut (
      .clk            (clk),
      .rst            (rst),
      .wr_valid_in    (wr_valid_in),
      .wr_ready_out   (wr_ready_out),
      .wr_data_in     (wr_data_in),
      .rd_valid_out   (rd_valid_out),
      .rd_ready_in    (rd_ready_in),
      .rd_data_out    (rd_data_out),
      .count_out      (count_out),
      .ram_we_a_out   (ram_we_a_out),
      .ram_addr_a_out (ram_addr_a_out),
      .ram_data_a_out (ram_data_a_out),
      .ram_we_b_out   (ram_we_b_out),
      .ram_addr_b_out (ram_addr_b_out),
      .ram_data_b_in  (ram_data_b_in)
   );

   always #5 clk = ~clk;

   // 64x8 RAM, registered read-first port B, so no write-to-read bypass exists.
   logic [7:0] mem [64];
   always @(posedge clk) begin
      if (ram_we_a_out) mem[ram_addr_a_out] <= ram_data_a_out;
      if (ram_we_b_out) mem[ram_addr_b_out] <= 8'h00;
      ram_data_b_in <= mem[ram_addr_b_out];
   end

   typedef struct {
      logic [7:0]  d;
      int unsigned e;
   } ent_t;

   ent_t        q[$];
   int unsigned edge_n = 0;
   int unsigned wcnt   = 0;
   int          errors = 0;
   int          checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: drive at negedge, check settled outputs, update model at posedge.
   task automatic cycle(input logic wv, input logic [7:0] wd, input logic rr,
                        output logic pushed, output logic popped);
      logic push_e, pop_e, exp_valid;
      wr_valid_in = wv;
      wr_data_in  = wd;
      rd_ready_in = rr;
      #1;
      push_e = wv & wr_ready_out;
      pop_e  = rd_valid_out & rr;
      exp_valid = 1'b0;
      if (q.size() > 0)
         if (edge_n - q[0].e >= 2) exp_valid = 1'b1;
      chk("we_a", 32'(ram_we_a_out), 32'(push_e));
      chk("we_b", 32'(ram_we_b_out), 32'd0);
      chk("count", 32'(count_out), 32'(q.size()));
      chk("rd_valid", 32'(rd_valid_out), 32'(exp_valid));
      if (rd_valid_out && q.size() > 0) chk("rd_data", 32'(rd_data_out), 32'(q[0].d));
      if (q.size() < 64)       chk("wr_ready", 32'(wr_ready_out), 32'd1);
      else if (q.size() == 66) chk("wr_ready_full", 32'(wr_ready_out), 32'd0);
      if (push_e) begin
         chk("addr_a", 32'(ram_addr_a_out), wcnt % 64);
         chk("data_a", 32'(ram_data_a_out), 32'(wd));
      end
      @(posedge clk);
      edge_n++;
      if (pop_e && q.size() > 0) void'(q.pop_front());
      if (push_e) begin
         q.push_back('{wd, edge_n});
         wcnt++;
      end
      @(negedge clk);
      pushed = push_e;
      popped = pop_e;
   endtask

   task automatic do_reset();
      #3;
      rst = 1'b1;
      wr_valid_in = 1'b0;
      rd_ready_in = 1'b0;
      #1;
      chk("rst_valid", 32'(rd_valid_out), 32'd0);
      chk("rst_data", 32'(rd_data_out), 32'd0);
      chk("rst_count", 32'(count_out), 32'd0);
      chk("rst_we_a", 32'(ram_we_a_out), 32'd0);
      chk("rst_we_b", 32'(ram_we_b_out), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      q.delete();
      wcnt = 0;
      #1;
      chk("rst_ready", 32'(wr_ready_out), 32'd1);
      #1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic p, pp;
      int unsigned n, cyc, got, first_pop, last_pop;
      logic [7:0] d;
      for (int unsigned i = 0; i < 64; i++) mem[i] = '0;
      @(negedge clk);

      // 1: single push, visible two edges later
      do_reset();
      cycle(1'b1, 8'hA5, 1'b0, p, pp);
      chk("t1_accept", 32'(p), 32'd1);
      cycle(1'b0, 8'h00, 1'b0, p, pp);
      chk("t1_not_yet", 32'(rd_valid_out), 32'd0);
      cycle(1'b0, 8'h00, 1'b0, p, pp);
      chk("t1_valid", 32'(rd_valid_out), 32'd1);
      chk("t1_data", 32'(rd_data_out), 32'hA5);
      chk("t1_count", 32'(count_out), 32'd1);

      // 2: fill to capacity
      do_reset();
      n = 0;
      cyc = 0;
      while (n < 66 && cyc < 200) begin
         cycle(1'b1, n[7:0], 1'b0, p, pp);
         cyc++;
         if (p) n++;
      end
      chk("t2_accepts", n, 32'd66);
      chk("t2_cycles", cyc, 32'd66);
      chk("t2_ready", 32'(wr_ready_out), 32'd0);
      chk("t2_count", 32'(count_out), 32'd66);
      wr_valid_in = 1'b1;
      #1;
      chk("t2_no_write", 32'(ram_we_a_out), 32'd0);
      cycle(1'b1, 8'hEE, 1'b0, p, pp);

      // 3: drain from full without gaps
      got = 0;
      cyc = 0;
      while (got < 66 && cyc < 200) begin
         cycle(1'b0, 8'h00, 1'b1, p, pp);
         cyc++;
         if (pp) got++;
      end
      chk("t3_pops", got, 32'd66);
      chk("t3_cycles", cyc, 32'd66);
      chk("t3_valid", 32'(rd_valid_out), 32'd0);
      chk("t3_count", 32'(count_out), 32'd0);

      // 4: streaming, both sides ready
      n = 0;
      got = 0;
      first_pop = 0;
      last_pop = 0;
      for (int unsigned c = 0; c < 400 && got < 200; c++) begin
         cycle(n < 200, n[7:0], 1'b1, p, pp);
         chk("t4_count_le3", 32'(count_out <= 7'd3), 32'd1);
         if (p) n++;
         if (pp) begin
            if (got == 0) first_pop = c;
            last_pop = c;
            got++;
         end
      end
      chk("t4_pops", got, 32'd200);
      chk("t4_rate", last_pop - first_pop + 1, 32'd200);

      // 5: random traffic with varying bias
      for (int unsigned seg = 0; seg < 10; seg++) begin
         int unsigned wb, rb;
         wb = $urandom_range(0, 4);
         rb = $urandom_range(0, 4);
         for (int unsigned c = 0; c < 500; c++) begin
            d = 8'($urandom);
            cycle($urandom_range(0, 3) < wb, d, $urandom_range(0, 3) < rb, p, pp);
         end
      end
      cyc = 0;
      while (q.size() > 0 && cyc < 300) begin
         cycle(1'b0, 8'h00, 1'b1, p, pp);
         cyc++;
      end
      chk("t5_drained", 32'(q.size()), 32'd0);

      // 6: reset mid-stream
      do_reset();
      for (int unsigned i = 0; i < 40; i++) cycle(1'b1, 8'($urandom), 1'b0, p, pp);
      chk("t6_count40", 32'(count_out), 32'd40);
      do_reset();
      cycle(1'b1, 8'h5C, 1'b0, p, pp);
      cyc = 0;
      while (!rd_valid_out && cyc < 5) begin
         cycle(1'b0, 8'h00, 1'b0, p, pp);
         cyc++;
      end
      chk("t6_valid", 32'(rd_valid_out), 32'd1);
      chk("t6_data", 32'(rd_data_out), 32'h5C);
      cycle(1'b0, 8'h00, 1'b1, p, pp);
      chk("t6_empty", 32'(count_out), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
